// File: rtl/decode_regread_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes
// and the D->E pipeline register layout with its bubble value.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        valC:  64'h0,
        valA:  64'h0,
        valB:  64'h0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

endpackage

// File: rtl/decode_regread_fwd_sel.sv
// Operand forwarding mux: picks the youngest in-flight producer of a source
// register, falling back to the register file value.
module fwd_sel
    import y86_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      src,
    input  logic [3:0]      e_dstE,
    input  logic [XLEN-1:0] e_valE,
    input  logic [3:0]      M_dstM,
    input  logic [XLEN-1:0] m_valM,
    input  logic [3:0]      M_dstE,
    input  logic [XLEN-1:0] M_valE,
    input  logic [3:0]      W_dstM,
    input  logic [XLEN-1:0] W_valM,
    input  logic [3:0]      W_dstE,
    input  logic [XLEN-1:0] W_valE,
    input  logic [XLEN-1:0] rf_val,
    output logic [XLEN-1:0] fwd_val
);

    // RNONE on the source side must never alias a "no destination" field.
    always_comb begin
        fwd_val = rf_val;
        if (src != RNONE) begin
            if (src == e_dstE)      fwd_val = e_valE;
            else if (src == M_dstM) fwd_val = m_valM;
            else if (src == M_dstE) fwd_val = M_valE;
            else if (src == W_dstM) fwd_val = W_valM;
            else if (src == W_dstE) fwd_val = W_valE;
        end
    end

endmodule

// File: rtl/decode_regread.sv
// Y86-64 decode stage: register ID decode, register file read, forwarding
// and the D->E pipeline register with stall/bubble control.
module decode_regread
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           D_stat,
    input  logic [3:0]           D_icode,
    input  logic [3:0]           D_ifun,
    input  logic [3:0]           D_rA,
    input  logic [3:0]           D_rB,
    input  logic [XLEN-1:0]      D_valC,
    input  logic [XLEN-1:0]      D_valP,
    input  logic [NREG*XLEN-1:0] reg_flat,
    input  logic [3:0]           e_dstE,
    input  logic [XLEN-1:0]      e_valE,
    input  logic [3:0]           M_dstE,
    input  logic [3:0]           M_dstM,
    input  logic [XLEN-1:0]      M_valE,
    input  logic [XLEN-1:0]      m_valM,
    input  logic [3:0]           W_dstE,
    input  logic [3:0]           W_dstM,
    input  logic [XLEN-1:0]      W_valE,
    input  logic [XLEN-1:0]      W_valM,
    input  logic                 E_stall,
    input  logic                 E_bubble,
    output logic [3:0]           d_srcA,
    output logic [3:0]           d_srcB,
    output logic [2:0]           E_stat,
    output logic [3:0]           E_icode,
    output logic [3:0]           E_ifun,
    output logic [XLEN-1:0]      E_valC,
    output logic [XLEN-1:0]      E_valA,
    output logic [XLEN-1:0]      E_valB,
    output logic [3:0]           E_dstE,
    output logic [3:0]           E_dstM,
    output logic [3:0]           E_srcA,
    output logic [3:0]           E_srcB
);

    logic [3:0]      srcA, srcB, dstE, dstM;
    logic [XLEN-1:0] rfA, rfB, fwdA, fwdB, valA;
    e_reg_t          eD, eQ;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (D_icode)
            IRRMOVQ: begin srcA = D_rA; dstE = D_rB; end
            IIRMOVQ: dstE = D_rB;
            IRMMOVQ: begin srcA = D_rA; srcB = D_rB; end
            IMRMOVQ: begin srcB = D_rB; dstM = D_rA; end
            IOPQ:    begin srcA = D_rA; srcB = D_rB; dstE = D_rB; end
            ICALL:   begin srcB = RRSP; dstE = RRSP; end
            IRET:    begin srcA = RRSP; srcB = RRSP; dstE = RRSP; end
            IPUSHQ:  begin srcA = D_rA; srcB = RRSP; dstE = RRSP; end
            IPOPQ:   begin srcA = RRSP; srcB = RRSP; dstE = RRSP; dstM = D_rA; end
            default: ;
        endcase
    end

    assign d_srcA = srcA;
    assign d_srcB = srcB;

    // Index RNONE falls through the loop and reads as zero.
    always_comb begin
        rfA = '0;
        rfB = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i)) rfA = reg_flat[i*XLEN +: XLEN];
            if (srcB == 4'(i)) rfB = reg_flat[i*XLEN +: XLEN];
        end
    end

    fwd_sel #(.XLEN(XLEN)) u_fwdA (
        .src(srcA), .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .M_dstE(M_dstE), .M_valE(M_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .rf_val(rfA), .fwd_val(fwdA)
    );

    fwd_sel #(.XLEN(XLEN)) u_fwdB (
        .src(srcB), .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .M_dstE(M_dstE), .M_valE(M_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .rf_val(rfB), .fwd_val(fwdB)
    );

    // call and jXX carry the return/fall-through address down the valA path.
    assign valA = (D_icode == ICALL || D_icode == IJXX) ? D_valP : fwdA;

    always_comb begin
        eD       = E_BUBBLE;
        eD.stat  = D_stat;
        eD.icode = D_icode;
        eD.ifun  = D_ifun;
        eD.valC  = D_valC;
        eD.valA  = valA;
        eD.valB  = fwdB;
        eD.dstE  = dstE;
        eD.dstM  = dstM;
        eD.srcA  = srcA;
        eD.srcB  = srcB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           eQ <= E_BUBBLE;
        else if (E_bubble) eQ <= E_BUBBLE;
        else if (!E_stall) eQ <= eD;
    end

    assign E_stat  = eQ.stat;
    assign E_icode = eQ.icode;
    assign E_ifun  = eQ.ifun;
    assign E_valC  = eQ.valC;
    assign E_valA  = eQ.valA;
    assign E_valB  = eQ.valB;
    assign E_dstE  = eQ.dstE;
    assign E_dstM  = eQ.dstM;
    assign E_srcA  = eQ.srcA;
    assign E_srcB  = eQ.srcB;

endmodule
